icache_responder: RTL and testbench

- Direct-mapped, read-only instruction cache. It sits on the responder side of the fetch-unit interface.
- Serves 32-bit word reads at the fetch address, with a `busywait_o` handshake that stalls the fetch unit.
- On a miss it refills one 4-word line from main memory over a request/busywait memory port.
- A flush (fence.i) invalidates all lines.

---
 rtl/icache_responder_pkg.sv | 13 +
 rtl/icache_tag_array.sv | 45 ++++
 rtl/icache_responder.sv | 118 +++++++++++
 tb/tb_icache_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_responder_pkg.sv
// Shared line geometry and FSM state encoding for the direct-mapped instruction cache.
package icache_responder_pkg;

    localparam int WORDS_PER_LINE = 4;
    localparam int LINE_BITS      = 32 * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        ICACHE_IDLE     = 2'd0,
        ICACHE_MEM_READ = 2'd1,
        ICACHE_UPDATE   = 2'd2
    } icache_state_t;

endpackage

// File: rtl/icache_tag_array.sv
// Per-line valid bits (with bulk flush clear) and tag storage, plus the hit compare.
module icache_tag_array
    import icache_responder_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 25
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INDEX_BITS-1:0] rd_index,
    input  logic [TAG_BITS-1:0]   rd_tag,
    output logic                  hit,
    input  logic                  clear_all,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic                  wr_valid
);

    localparam int NUM_LINES = 2 ** INDEX_BITS;

    logic [NUM_LINES-1:0] valid;
    logic [TAG_BITS-1:0]  tags [NUM_LINES];

    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid <= '0;
        end else begin
            if (clear_all)
                valid <= '0;
            if (wr_en)
                valid[wr_index] <= wr_valid;
        end
    end

    // NOTE: storage arrays carry no reset; the valid bits alone guard their contents.
    always_ff @(posedge clk_i) begin
        if (wr_en)
            tags[wr_index] <= wr_tag;
    end

    assign hit = valid[rd_index] && (tags[rd_index] == rd_tag);

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped read-only instruction cache: zero-latency hits, single-line refill on miss, fence.i flush.
module icache_responder
    import icache_responder_pkg::*;
#(
    parameter int INDEX_BITS = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 fetch_req_i,
    input  logic [29:0]          fetch_addr_i,
    input  logic                 flush_i,
    output logic [31:0]          data_o,
    output logic                 busywait_o,
    output logic                 mem_read_o,
    output logic [27:0]          mem_addr_o,
    input  logic [LINE_BITS-1:0] mem_readdata_i,
    input  logic                 mem_busywait_i
);

    localparam int TAG_BITS  = 30 - 2 - INDEX_BITS;
    localparam int NUM_LINES = 2 ** INDEX_BITS;

    icache_state_t state;
    logic          flush_pending;
    logic [LINE_BITS-1:0] line_buf;
    logic [LINE_BITS-1:0] data_array [NUM_LINES];

    logic [1:0]            fetch_offset;
    logic [INDEX_BITS-1:0] fetch_index;
    logic [TAG_BITS-1:0]   fetch_tag;
    logic [INDEX_BITS-1:0] refill_index;
    logic [TAG_BITS-1:0]   refill_tag;
    logic                  hit;
    logic                  flush_now;
    logic                  clear_all;
    logic                  line_write;

    assign fetch_offset = fetch_addr_i[1:0];
    assign fetch_index  = fetch_addr_i[INDEX_BITS+1:2];
    assign fetch_tag    = fetch_addr_i[29:INDEX_BITS+2];

    // The refill is steered by the registered line address, never the live fetch address.
    assign refill_index = mem_addr_o[INDEX_BITS-1:0];
    assign refill_tag   = mem_addr_o[27:INDEX_BITS];

    assign flush_now  = flush_pending | flush_i;
    assign line_write = (state == ICACHE_UPDATE);
    assign clear_all  = ((state == ICACHE_IDLE) && flush_i) || (line_write && flush_now);

    icache_tag_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_tag_array (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rd_index  (fetch_index),
        .rd_tag    (fetch_tag),
        .hit       (hit),
        .clear_all (clear_all),
        .wr_en     (line_write),
        .wr_index  (refill_index),
        .wr_tag    (refill_tag),
        .wr_valid  (~flush_now)
    );

    always_ff @(posedge clk_i) begin
        if (line_write)
            data_array[refill_index] <= line_buf;
    end

    assign data_o = data_array[fetch_index][{fetch_offset, 5'b0} +: 32];

    // NOTE: default assignment first so no path leaves busywait_o unassigned (no latch).
    always_comb begin
        busywait_o = 1'b1;
        if (state == ICACHE_IDLE)
            busywait_o = fetch_req_i & (~hit | flush_i);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= ICACHE_IDLE;
            mem_read_o    <= 1'b0;
            mem_addr_o    <= '0;
            flush_pending <= 1'b0;
            line_buf      <= '0;
        end else begin
            case (state)
                ICACHE_IDLE: begin
                    // A flush in this cycle suppresses any miss; the retry sees the cleared lines.
                    if (fetch_req_i && !hit && !flush_i) begin
                        state      <= ICACHE_MEM_READ;
                        mem_read_o <= 1'b1;
                        mem_addr_o <= fetch_addr_i[29:2];
                    end
                end
                ICACHE_MEM_READ: begin
                    if (flush_i)
                        flush_pending <= 1'b1;
                    if (!mem_busywait_i) begin
                        line_buf   <= mem_readdata_i;
                        mem_read_o <= 1'b0;
                        state      <= ICACHE_UPDATE;
                    end
                end
                ICACHE_UPDATE: begin
                    flush_pending <= 1'b0;
                    state         <= ICACHE_IDLE;
                end
                default: begin
                    state      <= ICACHE_IDLE;
                    mem_read_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench: random fetches against a line-level cache model and a latency-programmable memory.
module tb_icache_responder;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         fetch_req_i;
    logic [29:0]  fetch_addr_i;
    logic         flush_i;
    logic [31:0]  data_o;
    logic         busywait_o;
    logic         mem_read_o;
    logic [27:0]  mem_addr_o;
    logic [127:0] mem_readdata_i;
    logic         mem_busywait_i;

    int errors = 0;
    int checks = 0;

    int unsigned    mem_lat = 1;
    int unsigned    mem_cnt = 0;
    logic [27:0]    req_q [$];

    // Model: which line address each index holds, if any.
    bit             m_valid [8];
    int unsigned    m_line  [8];

    icache_responder dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .fetch_req_i    (fetch_req_i),
        .fetch_addr_i   (fetch_addr_i),
        .flush_i        (flush_i),
        .data_o         (data_o),
        .busywait_o     (busywait_o),
        .mem_read_o     (mem_read_o),
        .mem_addr_o     (mem_addr_o),
        .mem_readdata_i (mem_readdata_i),
        .mem_busywait_i (mem_busywait_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [29:0] w);
        return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic bit m_hit(input logic [29:0] a);
        int unsigned line = 32'(a) >> 2;
        return m_valid[line % 8] && (m_line[line % 8] == line);
    endfunction

    function automatic void m_fill(input logic [29:0] a);
        int unsigned line = 32'(a) >> 2;
        m_valid[line % 8] = 1'b1;
        m_line[line % 8]  = line;
    endfunction

    function automatic void m_flush();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory: answers mem_latency cycles after a request appears; logs each new request.
    initial begin
        mem_busywait_i = 1'b1;
        mem_readdata_i = '0;
        forever begin
            @(negedge clk_i);
            for (int k = 0; k < 4; k++)
                mem_readdata_i[32*k +: 32] = mem_word({mem_addr_o, 2'(k)});
            if (mem_read_o === 1'b1) begin
                if (mem_cnt == 0)
                    req_q.push_back(mem_addr_o);
                mem_cnt++;
                mem_busywait_i = (mem_cnt >= mem_lat) ? 1'b0 : 1'b1;
            end else begin
                mem_cnt        = 0;
                mem_busywait_i = 1'b1;
            end
        end
    end

    // Waits (bounded) for busywait_o to drop; returns the number of busy samples seen.
    task automatic wait_ready(output int stall);
        stall = 0;
        while (busywait_o !== 1'b0 && stall < 200) begin
            @(negedge clk_i);
            #1;
            stall++;
        end
        if (stall >= 200)
            check("busywait_timeout", 64'(stall), 64'd0);
    endtask

    task automatic do_fetch(input logic [29:0] a, input int unsigned lat, input string tag);
        bit exp_hit = m_hit(a);
        int n0 = req_q.size();
        int stall;
        mem_lat = lat;
        @(negedge clk_i);
        fetch_req_i  = 1'b1;
        fetch_addr_i = a;
        #1;
        wait_ready(stall);
        check({tag, "_stall"}, 64'(stall), exp_hit ? 64'd0 : 64'(lat + 2));
        check({tag, "_data"}, 64'(data_o), 64'(mem_word(a)));
        check({tag, "_mem_reqs"}, 64'(req_q.size() - n0), exp_hit ? 64'd0 : 64'd1);
        if (!exp_hit && req_q.size() > 0)
            check({tag, "_mem_addr"}, 64'(req_q[$]), 64'(a[29:2]));
        m_fill(a);
    endtask

    initial begin
        int          stall;
        int          n0;
        logic [29:0] a;
        logic [29:0] last;

        m_flush();
        rst_i        = 1'b0;
        fetch_req_i  = 1'b0;
        fetch_addr_i = '0;
        flush_i      = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("reset_mem_read", 64'(mem_read_o), 64'd0);
        check("reset_mem_addr", 64'(mem_addr_o), 64'd0);
        check("reset_busywait", 64'(busywait_o), 64'd0);

        // Cold miss at byte 0x40, then the rest of that line as hits.
        do_fetch(30'h10, 3, "cold_miss");
        do_fetch(30'h11, 1, "hit_w1");
        do_fetch(30'h12, 1, "hit_w2");
        do_fetch(30'h13, 1, "hit_w3");

        // Conflict on index 4: byte 0xC0 evicts 0x40, which then misses again.
        do_fetch(30'h30, 2, "conflict");
        do_fetch(30'h10, 1, "refetch_evicted");

        // Flush while the refill is in MEM_READ: the line is not kept, so the held fetch refills twice.
        n0 = req_q.size();
        mem_lat = 3;
        @(negedge clk_i);
        fetch_req_i  = 1'b1;
        fetch_addr_i = 30'h25;
        stall = 0;
        while (mem_read_o !== 1'b1 && stall < 50) begin
            @(negedge clk_i);
            stall++;
        end
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        wait_ready(stall);
        check("flush_refill_data", 64'(data_o), 64'(mem_word(30'h25)));
        check("flush_refill_reqs", 64'(req_q.size() - n0), 64'd2);
        m_flush();
        m_fill(30'h25);
        do_fetch(30'h24, 1, "after_flush_hit");

        // Flush in IDLE against a hit: flush wins and no miss starts in that cycle.
        n0 = req_q.size();
        @(negedge clk_i);
        fetch_req_i  = 1'b1;
        fetch_addr_i = 30'h26;
        #1;
        check("pre_flush_hit_busy", 64'(busywait_o), 64'd0);
        flush_i = 1'b1;
        #1;
        check("flush_hit_busy", 64'(busywait_o), 64'd1);
        @(negedge clk_i);
        flush_i     = 1'b0;
        fetch_req_i = 1'b0;
        #1;
        check("flush_no_miss", 64'(mem_read_o), 64'd0);
        check("flush_no_req", 64'(req_q.size() - n0), 64'd0);
        m_flush();
        do_fetch(30'h26, 2, "after_idle_flush");

        // Reset while the refill is outstanding.
        mem_lat = 4;
        @(negedge clk_i);
        fetch_req_i  = 1'b1;
        fetch_addr_i = 30'h4A;
        stall = 0;
        while (mem_read_o !== 1'b1 && stall < 50) begin
            @(negedge clk_i);
            stall++;
        end
        rst_i       = 1'b0;
        fetch_req_i = 1'b0;
        #1;
        check("midreset_mem_read", 64'(mem_read_o), 64'd0);
        check("midreset_mem_addr", 64'(mem_addr_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        m_flush();
        do_fetch(30'h4A, 2, "after_midreset");

        // Random fetches over 32 lines sharing 8 indexes, with random memory latency.
        last = 30'h4A;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0)
                a = {last[29:2], 2'($urandom_range(0, 3))};
            else
                a = 30'($urandom_range(0, 127));
            do_fetch(a, $urandom_range(1, 4), "random");
            last = a;
        end

        fetch_req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
